// File: rtl/lsq_rs_param_if.sv
// Dispatch, wakeup, commit, data-cache and result signals of the load/store reservation station.
// master = surrounding pipeline / memory, slave = the station itself.
interface lsq_rs_param_if #(
  parameter int unsigned TAG_W = 3
);
  logic             flush;
  logic             disp_valid;
  logic             disp_ready;
  logic             disp_is_store;
  logic [2:0]       disp_funct;
  logic [31:0]      disp_Vj;
  logic [31:0]      disp_Vk;
  logic [31:0]      disp_A;
  logic [TAG_W-1:0] disp_Qj;
  logic [TAG_W-1:0] disp_Qk;
  logic [TAG_W-1:0] disp_dest;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_val;
  logic             store_commit;
  logic             mem_read;
  logic [31:0]      mem_address;
  logic             mem_resp;
  logic [31:0]      mem_rdata;
  logic             ld_valid;
  logic [TAG_W-1:0] ld_tag;
  logic [31:0]      ld_val;
  logic             st_valid;
  logic [TAG_W-1:0] st_tag;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;

  modport master (
    output flush, disp_valid, disp_is_store, disp_funct, disp_Vj, disp_Vk, disp_A,
    output disp_Qj, disp_Qk, disp_dest, cdb_valid, cdb_tag, cdb_val, store_commit,
    output mem_resp, mem_rdata,
    input  disp_ready, mem_read, mem_address, ld_valid, ld_tag, ld_val,
    input  st_valid, st_tag, st_addr, st_data
  );

  modport slave (
    input  flush, disp_valid, disp_is_store, disp_funct, disp_Vj, disp_Vk, disp_A,
    input  disp_Qj, disp_Qk, disp_dest, cdb_valid, cdb_tag, cdb_val, store_commit,
    input  mem_resp, mem_rdata,
    output disp_ready, mem_read, mem_address, ld_valid, ld_tag, ld_val,
    output st_valid, st_tag, st_addr, st_data
  );
endinterface

// File: rtl/lsq_rs_param.sv
// Load/store reservation station: tracks operands of in-flight memory ops, resolves stores to
// the ROB and issues loads (oldest eligible first) to the data cache one at a time.
module lsq_rs_param #(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned TAG_W       = 3,
  parameter int unsigned MAX_STORES  = 8
) (
  input logic           clk,
  input logic           rst,
  lsq_rs_param_if.slave bus
);
  localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_STORES + 1);
  // Wide enough that live entries never span half the sequence space.
  localparam int unsigned SEQ_W = 8;

  typedef enum logic [1:0] {StIdle, StReq, StDrain} ld_state_e;

  ld_state_e state_q, state_d;

  logic [NUM_ENTRIES-1:0] busy_q, is_store_q;
  logic [2:0]             funct_q [NUM_ENTRIES];
  logic [31:0]            vj_q    [NUM_ENTRIES];
  logic [31:0]            vk_q    [NUM_ENTRIES];
  logic [31:0]            a_q     [NUM_ENTRIES];
  logic [TAG_W-1:0]       qj_q    [NUM_ENTRIES];
  logic [TAG_W-1:0]       qk_q    [NUM_ENTRIES];
  logic [TAG_W-1:0]       dest_q  [NUM_ENTRIES];
  logic [CNT_W-1:0]       sb_q    [NUM_ENTRIES];
  logic [SEQ_W-1:0]       seq_q   [NUM_ENTRIES];
  logic [CNT_W-1:0]       store_cnt_q;
  logic [SEQ_W-1:0]       seq_ctr_q;

  logic [IDX_W-1:0] ld_slot_q;
  logic [1:0]       ld_off_q;
  logic [2:0]       ld_funct_q;
  logic [TAG_W-1:0] ld_dest_q;
  logic [31:0]      mem_address_q;

  logic             ld_valid_q, st_valid_q;
  logic [TAG_W-1:0] ld_tag_q, st_tag_q;
  logic [31:0]      ld_val_q, st_addr_q, st_data_q;

  logic             alloc_found, disp_fire, disp_hit_j, disp_hit_k;
  logic [IDX_W-1:0] alloc_idx, st_idx, ld_idx;
  logic             st_found, ld_found, issue, ld_done;
  logic [SEQ_W-1:0] ld_seq;
  logic [CNT_W-1:0] sb_new;
  logic [NUM_ENTRIES-1:0] hit_j, hit_k, free_vec;
  logic [31:0]      ld_ea, ld_ext, rdata_shift;

  function automatic logic seq_older(logic [SEQ_W-1:0] a, logic [SEQ_W-1:0] b);
    logic [SEQ_W-1:0] d;
    d = a - b;
    return d[SEQ_W-1];
  endfunction

  // Entry selection: lowest free slot, lowest resolved store, oldest eligible load.
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    st_found    = 1'b0;
    st_idx      = '0;
    ld_found    = 1'b0;
    ld_idx      = '0;
    ld_seq      = '0;
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      if (!alloc_found && !busy_q[i]) begin
        alloc_found = 1'b1;
        alloc_idx   = IDX_W'(i);
      end
      if (!st_found && busy_q[i] && is_store_q[i] && qj_q[i] == '0 && qk_q[i] == '0) begin
        st_found = 1'b1;
        st_idx   = IDX_W'(i);
      end
      if (busy_q[i] && !is_store_q[i] && qj_q[i] == '0 && sb_q[i] == '0) begin
        if (!ld_found || seq_older(seq_q[i], ld_seq)) begin
          ld_found = 1'b1;
          ld_idx   = IDX_W'(i);
          ld_seq   = seq_q[i];
        end
      end
    end
  end

  // Wakeup matches against the result bus, for resident entries and the incoming dispatch.
  always_comb begin
    hit_j = '0;
    hit_k = '0;
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      hit_j[i] = bus.cdb_valid && (qj_q[i] != '0) && (qj_q[i] == bus.cdb_tag);
      hit_k[i] = bus.cdb_valid && (qk_q[i] != '0) && (qk_q[i] == bus.cdb_tag);
    end
    disp_hit_j = bus.cdb_valid && (bus.disp_Qj != '0) && (bus.disp_Qj == bus.cdb_tag);
    disp_hit_k = bus.cdb_valid && (bus.disp_Qk != '0) && (bus.disp_Qk == bus.cdb_tag);
  end

  assign bus.disp_ready = alloc_found && (state_q != StDrain);
  assign disp_fire      = bus.disp_valid && bus.disp_ready && !bus.flush;
  // A commit in the dispatch cycle already retires one of the stores counted here.
  assign sb_new = (bus.store_commit && store_cnt_q != '0) ? store_cnt_q - 1'b1 : store_cnt_q;
  assign ld_ea  = vj_q[ld_idx] + a_q[ld_idx];

  // Slots released this cycle: resolved store and completed load.
  always_comb begin
    free_vec = '0;
    if (st_found) free_vec[st_idx] = 1'b1;
    if (ld_done) free_vec[ld_slot_q] = 1'b1;
  end

  // Entry array: allocation, operand wakeup, store_before tracking and frees.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      is_store_q <= '0;
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        funct_q[i] <= '0;
        vj_q[i]    <= '0;
        vk_q[i]    <= '0;
        a_q[i]     <= '0;
        qj_q[i]    <= '0;
        qk_q[i]    <= '0;
        dest_q[i]  <= '0;
        sb_q[i]    <= '0;
        seq_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        if (bus.flush) begin
          busy_q[i] <= 1'b0;
          qj_q[i]   <= '0;
          qk_q[i]   <= '0;
        end else if (disp_fire && (alloc_idx == IDX_W'(i))) begin
          busy_q[i]     <= 1'b1;
          is_store_q[i] <= bus.disp_is_store;
          funct_q[i]    <= bus.disp_funct;
          a_q[i]        <= bus.disp_A;
          dest_q[i]     <= bus.disp_dest;
          sb_q[i]       <= sb_new;
          seq_q[i]      <= seq_ctr_q;
          qj_q[i]       <= disp_hit_j ? '0 : bus.disp_Qj;
          vj_q[i]       <= disp_hit_j ? bus.cdb_val : bus.disp_Vj;
          qk_q[i]       <= disp_hit_k ? '0 : bus.disp_Qk;
          vk_q[i]       <= disp_hit_k ? bus.cdb_val : bus.disp_Vk;
        end else if (busy_q[i]) begin
          if (free_vec[i]) busy_q[i] <= 1'b0;
          if (hit_j[i]) begin
            qj_q[i] <= '0;
            vj_q[i] <= bus.cdb_val;
          end
          if (hit_k[i]) begin
            qk_q[i] <= '0;
            vk_q[i] <= bus.cdb_val;
          end
          if (bus.store_commit && !is_store_q[i] && sb_q[i] != '0) sb_q[i] <= sb_q[i] - 1'b1;
        end
      end
    end
  end

  // Outstanding-store count (saturating) and allocation sequence counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_cnt_q <= '0;
      seq_ctr_q   <= '0;
    end else begin
      if (disp_fire) seq_ctr_q <= seq_ctr_q + 1'b1;
      if (bus.flush) begin
        store_cnt_q <= '0;
      end else if (disp_fire && bus.disp_is_store && !bus.store_commit) begin
        if (store_cnt_q != CNT_W'(MAX_STORES)) store_cnt_q <= store_cnt_q + 1'b1;
      end else if (bus.store_commit && !(disp_fire && bus.disp_is_store)) begin
        if (store_cnt_q != '0) store_cnt_q <= store_cnt_q - 1'b1;
      end
    end
  end

  // Load FSM next state: issue from IDLE, complete or squash in REQ, wait out the reply in DRAIN.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    ld_done = 1'b0;
    case (state_q)
      StIdle: begin
        if (!bus.flush && ld_found) begin
          state_d = StReq;
          issue   = 1'b1;
        end
      end
      StReq: begin
        if (bus.flush) begin
          state_d = bus.mem_resp ? StIdle : StDrain;
        end else if (bus.mem_resp) begin
          state_d = StIdle;
          ld_done = 1'b1;
        end
      end
      StDrain: begin
        if (bus.mem_resp) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Load FSM state and the latched request context.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      ld_slot_q     <= '0;
      ld_off_q      <= '0;
      ld_funct_q    <= '0;
      ld_dest_q     <= '0;
      mem_address_q <= '0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        ld_slot_q     <= ld_idx;
        ld_off_q      <= ld_ea[1:0];
        ld_funct_q    <= funct_q[ld_idx];
        ld_dest_q     <= dest_q[ld_idx];
        mem_address_q <= {ld_ea[31:2], 2'b00};
      end
    end
  end

  assign bus.mem_read    = (state_q != StIdle);
  assign bus.mem_address = mem_address_q;

  // Byte/halfword extraction of the returned word.
  always_comb begin
    rdata_shift = bus.mem_rdata >> {ld_off_q, 3'b000};
    case (ld_funct_q)
      3'b000:  ld_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      3'b001:  ld_ext = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      3'b100:  ld_ext = {24'b0, rdata_shift[7:0]};
      3'b101:  ld_ext = {16'b0, rdata_shift[15:0]};
      default: ld_ext = bus.mem_rdata;
    endcase
  end

  // Registered load result and resolved-store record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_valid_q <= 1'b0;
      ld_tag_q   <= '0;
      ld_val_q   <= '0;
      st_valid_q <= 1'b0;
      st_tag_q   <= '0;
      st_addr_q  <= '0;
      st_data_q  <= '0;
    end else begin
      ld_valid_q <= ld_done;
      if (ld_done) begin
        ld_tag_q <= ld_dest_q;
        ld_val_q <= ld_ext;
      end
      st_valid_q <= st_found && !bus.flush;
      if (st_found && !bus.flush) begin
        st_tag_q  <= dest_q[st_idx];
        st_addr_q <= vj_q[st_idx] + a_q[st_idx];
        st_data_q <= vk_q[st_idx];
      end
    end
  end

  assign bus.ld_valid = ld_valid_q;
  assign bus.ld_tag   = ld_tag_q;
  assign bus.ld_val   = ld_val_q;
  assign bus.st_valid = st_valid_q;
  assign bus.st_tag   = st_tag_q;
  assign bus.st_addr  = st_addr_q;
  assign bus.st_data  = st_data_q;
endmodule
